// File: rtl/pll_lock_ctrl.sv
// PLL acquisition sequencer: resets the PLL, waits for it to settle, then watches
// the PFD for sustained quiet to declare lock, stepping through coarse bands on timeout.
module pll_lock_ctrl #(
  parameter int unsigned         TW_WIDTH      = 32,
  parameter logic [TW_WIDTH-1:0] BASE_WORD     = '0,
  parameter logic [TW_WIDTH-1:0] STEP_WORD     = TW_WIDTH'(32'h0100_0000),
  parameter int unsigned         NUM_BANDS     = 4,
  parameter int unsigned         RST_CYCLES    = 4,
  parameter int unsigned         SETTLE_CYCLES = 16,
  parameter int unsigned         LOCK_COUNT    = 64,
  parameter int unsigned         UNLOCK_COUNT  = 4,
  parameter int unsigned         TIMEOUT       = 1024
) (
  input  logic                ref_clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                up,
  input  logic                down,
  output logic                pll_rst_n,
  output logic [TW_WIDTH-1:0] preset_word,
  output logic [3:0]          band,
  output logic                locked,
  output logic                fail,
  output logic [2:0]          state,
  output logic [7:0]          relock_cnt
);

  localparam int unsigned MaxA   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MaxB   = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int unsigned MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(MaxCnt);
  localparam int unsigned TmoW   = $clog2(TIMEOUT);

  localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_COUNT - 1);
  localparam logic [CntW-1:0] UnlockLast = CntW'(UNLOCK_COUNT - 1);
  localparam logic [TmoW-1:0] TmoLast    = TmoW'(TIMEOUT - 1);
  localparam logic [3:0]      LastBand   = 4'(NUM_BANDS - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StResetPll = 3'd1,
    StSettle   = 3'd2,
    StAcquire  = 3'd3,
    StLocked   = 3'd4,
    StFail     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [3:0]          band_q, band_d;
  logic [7:0]          relock_q, relock_d;
  logic [TW_WIDTH-1:0] preset_q;
  logic                pll_rst_n_q, locked_q, fail_q;
  logic                up_meta_q, up_sync_q, dn_meta_q, dn_sync_q;
  logic                quiet;

  assign quiet = ~(up_sync_q | dn_sync_q);

  // cnt_q is the phase counter: cycles in RESET_PLL/SETTLE, quiet run in ACQUIRE,
  // noisy run in LOCKED.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    band_d   = band_q;
    relock_d = relock_q;
    case (state_q)
      StIdle: begin
        band_d = '0;
        if (enable) state_d = StResetPll;
      end
      StResetPll: begin
        if (cnt_q == RstLast) state_d = StSettle;
        else                  cnt_d   = cnt_q + CntW'(1);
      end
      StSettle: begin
        if (cnt_q == SettleLast) state_d = StAcquire;
        else                     cnt_d   = cnt_q + CntW'(1);
      end
      StAcquire: begin
        tmo_d = tmo_q + TmoW'(1);
        cnt_d = quiet ? cnt_q + CntW'(1) : '0;
        if (quiet && cnt_q == LockLast) begin
          state_d = StLocked;
        end else if (tmo_q == TmoLast) begin
          if (band_q != LastBand) begin
            band_d  = band_q + 4'd1;
            state_d = StResetPll;
          end else begin
            state_d = StFail;
          end
        end
      end
      StLocked: begin
        if (quiet) begin
          cnt_d = '0;
        end else if (cnt_q == UnlockLast) begin
          state_d = StResetPll;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFail: ;
      default: state_d = StIdle;
    endcase
    if (!enable) begin
      state_d  = StIdle;
      band_d   = '0;
      relock_d = relock_q;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
      tmo_d = '0;
    end
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tmo_q       <= '0;
      band_q      <= '0;
      relock_q    <= '0;
      preset_q    <= BASE_WORD;
      pll_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      up_meta_q   <= 1'b0;
      up_sync_q   <= 1'b0;
      dn_meta_q   <= 1'b0;
      dn_sync_q   <= 1'b0;
    end else begin
      up_meta_q   <= up;
      up_sync_q   <= up_meta_q;
      dn_meta_q   <= down;
      dn_sync_q   <= dn_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      band_q      <= band_d;
      relock_q    <= relock_d;
      preset_q    <= BASE_WORD + STEP_WORD * TW_WIDTH'(band_q);
      pll_rst_n_q <= (state_d == StSettle) || (state_d == StAcquire) || (state_d == StLocked);
      locked_q    <= (state_d == StLocked);
      fail_q      <= (state_d == StFail);
    end
  end

  assign state       = state_q;
  assign band        = band_q;
  assign relock_cnt  = relock_q;
  assign preset_word = preset_q;
  assign pll_rst_n   = pll_rst_n_q;
  assign locked      = locked_q;
  assign fail        = fail_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: vector tables with hand-derived expectations, queued as a
// scoreboard and checked once each vector's cycles have elapsed.
module tb_pll_lock_ctrl;

  logic        ref_clk = 1'b0;
  logic        rst_n, enable, up, down;
  logic        pll_rst_n, locked, fail;
  logic [31:0] preset_word;
  logic [3:0]  band;
  logic [2:0]  state;
  logic [7:0]  relock_cnt;

  always #5 ref_clk = ~ref_clk;

  pll_lock_ctrl dut (
    .ref_clk     (ref_clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .up          (up),
    .down        (down),
    .pll_rst_n   (pll_rst_n),
    .preset_word (preset_word),
    .band        (band),
    .locked      (locked),
    .fail        (fail),
    .state       (state),
    .relock_cnt  (relock_cnt)
  );

  localparam logic [31:0] P0 = 32'h0000_0000;
  localparam logic [31:0] P1 = 32'h0100_0000;
  localparam logic [31:0] P2 = 32'h0200_0000;
  localparam logic [31:0] P3 = 32'h0300_0000;

  typedef struct packed {
    logic        en, up, dn, tog;
    logic [15:0] n;
    logic [2:0]  st;
    logic        prst, lk, fl;
    logic [3:0]  band;
    logic [31:0] pre;
    logic [7:0]  rl;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  vec_t  tbl[$];
  string tnm[$];
  vec_t  exp_q[$];
  string exp_nm[$];

  function automatic vec_t mk(logic en, logic u, logic dn, logic tog, int n, logic [2:0] st,
                              logic prst, logic lk, logic fl, logic [3:0] bnd,
                              logic [31:0] pre, logic [7:0] rl);
    vec_t v;
    v.en = en; v.up = u; v.dn = dn; v.tog = tog; v.n = 16'(n);
    v.st = st; v.prst = prst; v.lk = lk; v.fl = fl; v.band = bnd; v.pre = pre; v.rl = rl;
    return v;
  endfunction

  task automatic compare(string nm, vec_t e);
    total++;
    if (state !== e.st || pll_rst_n !== e.prst || locked !== e.lk || fail !== e.fl ||
        band !== e.band || preset_word !== e.pre || relock_cnt !== e.rl) begin
      bad++;
      $display("FAIL %s: got st=%0d prst=%0b lk=%0b fl=%0b band=%0d pre=%h rl=%0d | want st=%0d prst=%0b lk=%0b fl=%0b band=%0d pre=%h rl=%0d",
               nm, state, pll_rst_n, locked, fail, band, preset_word, relock_cnt,
               e.st, e.prst, e.lk, e.fl, e.band, e.pre, e.rl);
    end
  endtask

  // Drive the vector's inputs for n cycles, then check the expectation queued for it.
  task automatic run_vec(string nm, vec_t v);
    vec_t  e;
    string ename;
    enable = v.en;
    down   = v.dn;
    if (!v.tog) up = v.up;
    exp_q.push_back(v);
    exp_nm.push_back(nm);
    for (int i = 0; i < int'(v.n); i++) begin
      if (v.tog) up = ~up;
      @(posedge ref_clk);
      #1;
    end
    e     = exp_q.pop_front();
    ename = exp_nm.pop_front();
    compare(ename, e);
  endtask

  task automatic add(string nm, vec_t v);
    tbl.push_back(v);
    tnm.push_back(nm);
  endtask

  task automatic flush();
    for (int i = 0; i < tbl.size(); i++) run_vec(tnm[i], tbl[i]);
    tbl.delete();
    tnm.delete();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; up = 1'b0; down = 1'b0;
    repeat (2) @(posedge ref_clk);
    #1;
    compare("reset", mk(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 4'd0, P0, 8'd0));
    rst_n = 1'b1;

    // Clean acquisition, glitch tolerance in LOCKED, lock loss and disable paths.
    add("idle",          mk(0, 0, 0, 0, 2,  3'd0, 0, 0, 0, 4'd0, P0, 8'd0));
    add("rst_pll_entry", mk(1, 0, 0, 0, 1,  3'd1, 0, 0, 0, 4'd0, P0, 8'd0));
    add("rst_pll_hold",  mk(1, 0, 0, 0, 3,  3'd1, 0, 0, 0, 4'd0, P0, 8'd0));
    add("settle_entry",  mk(1, 0, 0, 0, 1,  3'd2, 1, 0, 0, 4'd0, P0, 8'd0));
    add("settle_hold",   mk(1, 0, 0, 0, 15, 3'd2, 1, 0, 0, 4'd0, P0, 8'd0));
    add("acq_entry",     mk(1, 0, 0, 0, 1,  3'd3, 1, 0, 0, 4'd0, P0, 8'd0));
    add("acq_63",        mk(1, 0, 0, 0, 63, 3'd3, 1, 0, 0, 4'd0, P0, 8'd0));
    add("lock_64",       mk(1, 0, 0, 0, 1,  3'd4, 1, 1, 0, 4'd0, P0, 8'd0));
    add("dn3_on",        mk(1, 0, 1, 0, 3,  3'd4, 1, 1, 0, 4'd0, P0, 8'd0));
    add("dn3_stay",      mk(1, 0, 0, 0, 5,  3'd4, 1, 1, 0, 4'd0, P0, 8'd0));
    add("dn4_on",        mk(1, 0, 1, 0, 4,  3'd4, 1, 1, 0, 4'd0, P0, 8'd0));
    add("dn4_cnt3",      mk(1, 0, 0, 0, 1,  3'd4, 1, 1, 0, 4'd0, P0, 8'd0));
    add("dn4_unlock",    mk(1, 0, 0, 0, 1,  3'd1, 0, 0, 0, 4'd0, P0, 8'd1));
    add("relock_acq",    mk(1, 0, 0, 0, 83, 3'd3, 1, 0, 0, 4'd0, P0, 8'd1));
    add("relock",        mk(1, 0, 0, 0, 1,  3'd4, 1, 1, 0, 4'd0, P0, 8'd1));
    add("dis_locked",    mk(0, 0, 0, 0, 1,  3'd0, 0, 0, 0, 4'd0, P0, 8'd1));
    add("settle_again",  mk(1, 0, 0, 0, 5,  3'd2, 1, 0, 0, 4'd0, P0, 8'd1));
    add("dis_settle",    mk(0, 0, 0, 0, 1,  3'd0, 0, 0, 0, 4'd0, P0, 8'd1));
    add("acq_pre_rst",   mk(1, 0, 0, 0, 25, 3'd3, 1, 0, 0, 4'd0, P0, 8'd1));
    flush();

    // Asynchronous reset in the middle of ACQUIRE, held with enable still high.
    #2;
    rst_n = 1'b0;
    #1;
    compare("rst_async", mk(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 4'd0, P0, 8'd0));
    repeat (3) @(posedge ref_clk);
    #1;
    compare("rst_hold", mk(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 4'd0, P0, 8'd0));
    enable = 1'b0;
    rst_n  = 1'b1;

    // PFD never quiet long enough: walk all bands, then FAIL until disabled.
    add("rel_idle",  mk(0, 0, 0, 0, 2,    3'd0, 0, 0, 0, 4'd0, P0, 8'd0));
    add("tmo_start", mk(1, 0, 0, 1, 1,    3'd1, 0, 0, 0, 4'd0, P0, 8'd0));
    add("tmo0_acq",  mk(1, 0, 0, 1, 1043, 3'd3, 1, 0, 0, 4'd0, P0, 8'd0));
    add("tmo0_hit",  mk(1, 0, 0, 1, 1,    3'd1, 0, 0, 0, 4'd1, P0, 8'd0));
    add("pre1",      mk(1, 0, 0, 1, 1,    3'd1, 0, 0, 0, 4'd1, P1, 8'd0));
    add("tmo1_acq",  mk(1, 0, 0, 1, 1042, 3'd3, 1, 0, 0, 4'd1, P1, 8'd0));
    add("tmo1_hit",  mk(1, 0, 0, 1, 1,    3'd1, 0, 0, 0, 4'd2, P1, 8'd0));
    add("pre2",      mk(1, 0, 0, 1, 1,    3'd1, 0, 0, 0, 4'd2, P2, 8'd0));
    add("tmo2_acq",  mk(1, 0, 0, 1, 1042, 3'd3, 1, 0, 0, 4'd2, P2, 8'd0));
    add("tmo2_hit",  mk(1, 0, 0, 1, 1,    3'd1, 0, 0, 0, 4'd3, P2, 8'd0));
    add("pre3",      mk(1, 0, 0, 1, 1,    3'd1, 0, 0, 0, 4'd3, P3, 8'd0));
    add("tmo3_acq",  mk(1, 0, 0, 1, 1042, 3'd3, 1, 0, 0, 4'd3, P3, 8'd0));
    add("fail",      mk(1, 0, 0, 1, 1,    3'd5, 0, 0, 1, 4'd3, P3, 8'd0));
    add("fail_hold", mk(1, 0, 0, 1, 20,   3'd5, 0, 0, 1, 4'd3, P3, 8'd0));
    add("dis_fail",  mk(0, 0, 0, 0, 1,    3'd0, 0, 0, 0, 4'd0, P3, 8'd0));
    add("pre_clr",   mk(0, 0, 0, 0, 1,    3'd0, 0, 0, 0, 4'd0, P0, 8'd0));
    // Lock completes on the very last ACQUIRE cycle of band 0: lock must win.
    add("late_noisy", mk(1, 1, 0, 0, 979, 3'd3, 1, 0, 0, 4'd0, P0, 8'd0));
    add("late_quiet", mk(1, 0, 0, 0, 65,  3'd3, 1, 0, 0, 4'd0, P0, 8'd0));
    add("late_lock",  mk(1, 0, 0, 0, 1,   3'd4, 1, 1, 0, 4'd0, P0, 8'd0));
    flush();

    // Repeated forced lock losses: relock_cnt saturates at 255.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] rp, rn;
      rp = (i > 255) ? 8'd255 : 8'(i);
      rn = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      run_vec("loss_on",   mk(1, 0, 1, 0, 4,  3'd4, 1, 1, 0, 4'd0, P0, rp));
      run_vec("loss_cnt3", mk(1, 0, 0, 0, 1,  3'd4, 1, 1, 0, 4'd0, P0, rp));
      run_vec("loss_rst",  mk(1, 0, 0, 0, 1,  3'd1, 0, 0, 0, 4'd0, P0, rn));
      run_vec("loss_acq",  mk(1, 0, 0, 0, 83, 3'd3, 1, 0, 0, 4'd0, P0, rn));
      run_vec("loss_lock", mk(1, 0, 0, 0, 1,  3'd4, 1, 1, 0, 4'd0, P0, rn));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter TW_WIDTH, default 32, meaning tuning/preset word width.
REQ-002 SHALL have parameter BASE_WORD, default 32'd0, meaning preset word for band 0.
REQ-003 SHALL have parameter STEP_WORD, default 32'h0100_0000, meaning preset increment per band.
REQ-004 SHALL have parameter NUM_BANDS, default 4, meaning coarse bands tried, 1..16.
REQ-005 SHALL have parameters RST_CYCLES=4, SETTLE_CYCLES=16, LOCK_COUNT=64, UNLOCK_COUNT=4, TIMEOUT=1024, all >=2, all in ref_clk cycles.
REQ-006 SHALL have port ref_clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1, level request to run acquisition.
REQ-009 SHALL have ports up and down, input, 1 each, raw PFD outputs, asynchronous to ref_clk.
REQ-010 SHALL have port pll_rst_n, output, 1, active-low reset to PFD, loop filter, divider.
REQ-011 SHALL have port preset_word, output, TW_WIDTH, coarse initial frequency word for the loop filter.
REQ-012 SHALL have port band, output, 4, current coarse band index.
REQ-013 SHALL have ports locked and fail, output, 1 each, status flags.
REQ-014 SHALL have port state, output, 3, current FSM state encoding.
REQ-015 SHALL have port relock_cnt, output, 8, count of lock losses, saturating.

Function
REQ-016 SHALL pass up and down each through a 2-flop synchronizer; quiet = both synchronized bits 0.
REQ-017 SHALL implement states IDLE=0, RESET_PLL=1, SETTLE=2, ACQUIRE=3, LOCKED=4, FAIL=5; codes 6-7 SHALL go to IDLE next cycle.
REQ-018 SHALL, in any state, with enable=0, enter IDLE next cycle; enable has priority over every other transition.
REQ-019 IDLE: pll_rst_n=0, locked=0, fail=0, band cleared to 0; enable=1 -> RESET_PLL.
REQ-020 RESET_PLL: pll_rst_n=0 for exactly RST_CYCLES cycles, then -> SETTLE.
REQ-021 SETTLE: pll_rst_n=1; up/down ignored; after exactly SETTLE_CYCLES cycles -> ACQUIRE.
REQ-022 ACQUIRE: lock counter increments on each quiet cycle, clears to 0 on any non-quiet cycle; the quiet cycle bringing it to LOCK_COUNT -> LOCKED.
REQ-023 ACQUIRE: timeout counter counts every cycle from entry; at TIMEOUT cycles without lock, band<NUM_BANDS-1 -> band+1 and RESET_PLL, else -> FAIL.
REQ-024 SHALL give lock priority over timeout when both occur in the same cycle.
REQ-025 LOCKED: locked=1; unlock counter increments per non-quiet cycle, clears on quiet cycle; reaching UNLOCK_COUNT -> RESET_PLL, band unchanged, relock_cnt+1 saturating at 255.
REQ-026 FAIL: fail=1, pll_rst_n=0, locked=0; held until enable=0.
REQ-027 locked SHALL be 1 only in LOCKED; fail SHALL be 1 only in FAIL; both registered.
REQ-028 preset_word SHALL be registered BASE_WORD + band*STEP_WORD, modulo 2^TW_WIDTH, updated the cycle after band changes, stable while pll_rst_n=1.
REQ-029 All counters SHALL clear on every state entry; no counter wraps.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, pll_rst_n=0, locked=0, fail=0, band=0, preset_word=BASE_WORD, relock_cnt=0, synchronizers and counters 0.
REQ-031 relock_cnt SHALL clear only on rst_n, not on IDLE.
REQ-032 Reset asserted mid-operation SHALL abort any state with no further output change until release plus enable.

Verification
REQ-033 enable=1, up=down=0 always -> pll_rst_n rises after 4 cycles, ACQUIRE after 16 more, locked=1 after 64 quiet ACQUIRE cycles (+2-cycle sync), band=0.
REQ-034 up toggling every cycle in ACQUIRE -> timeouts step band 0->1->2->3, preset_word 0,0x0100_0000,0x0200_0000,0x0300_0000; 4th timeout -> fail=1, state=5.
REQ-035 LOCKED, down held 1 for 3 cycles then 0 -> stays LOCKED; held 4 cycles -> RESET_PLL, relock_cnt=1, band unchanged.
REQ-036 Lock count reaching 64 on the 1024th ACQUIRE cycle -> LOCKED, band unchanged.
REQ-037 enable=0 during SETTLE, LOCKED, FAIL -> IDLE next cycle, band=0; rst_n pulse mid-ACQUIRE -> all REQ-030 values immediately.
REQ-038 256 forced lock losses -> relock_cnt holds 255.
